// File: rtl/usb_data_packetizer.sv
// USB data packet framer: emits the PID byte, passes the payload straight through,
// then appends the CRC-16/USB trailer (low byte first).
module usb_data_packetizer #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic       zlp,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       len_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PID    = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] CRC_LO = 3'd3;
    localparam logic [2:0] CRC_HI = 3'd4;

    localparam logic [9:0] MAX_CNT = 10'(MAX_BYTES);

    logic [2:0]  state;
    logic [3:0]  pid_q;
    logic        zlp_q;
    logic [15:0] crc;
    logic [9:0]  count;

    // Reflected CRC-16/USB, one byte consumed LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? 16'hA001 : 16'h0000);
        end
        return c;
    endfunction

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        tx_valid = 1'b0;
        in_ready = 1'b0;
        tx_data  = 8'h00;
        case (state)
            PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
            end
            DATA: begin
                tx_valid = in_valid;
                in_ready = tx_ready;
                tx_data  = in_data;
            end
            CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc[7:0];
            end
            CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc[15:8];
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pid_q   <= 4'h0;
            zlp_q   <= 1'b0;
            crc     <= 16'hFFFF;
            count   <= 10'd0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pid_q <= pid;
                        zlp_q <= zlp;
                        crc   <= 16'hFFFF;
                        count <= 10'd0;
                        state <= PID;
                    end
                end
                PID: begin
                    if (tx_ready) state <= zlp_q ? CRC_LO : DATA;
                end
                DATA: begin
                    if (in_valid && tx_ready) begin
                        crc   <= crc16_byte(crc, in_data);
                        count <= count + 10'd1;
                        if (in_last) begin
                            state <= CRC_LO;
                        end else if (count + 10'd1 == MAX_CNT) begin
                            // Payload hit the limit without a terminator: close the packet and flag it.
                            len_err <= 1'b1;
                            state   <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (tx_ready) state <= CRC_HI;
                end
                CRC_HI: begin
                    if (tx_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_data_packetizer.md
USB_DATA_PACKETIZER -- requirements
Module: usb_data_packetizer

Interface
REQ-001 Parameter MAX_BYTES, default 64: maximum payload bytes per packet; legal range 1..1023.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a packet; sampled only in IDLE.
REQ-005 pid  input  4  packet PID, sampled with start (DATA0=4'h3, DATA1=4'hB).
REQ-006 zlp  input  1  zero-length packet flag, sampled with start.
REQ-007 in_data  input  8  payload byte from the source.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_last  input  1  marks the final payload byte; qualified by in_valid.
REQ-010 in_ready  output  1  payload byte accepted this cycle when in_valid is also high.
REQ-011 tx_data  output  8  byte to the downstream transmitter.
REQ-012 tx_valid  output  1  tx_data valid.
REQ-013 tx_ready  input  1  downstream accepts tx_data this cycle when tx_valid is also high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse marking packet completion.
REQ-016 len_err  output  1  one-cycle pulse marking payload overrun.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, PID, DATA, CRC_LO, CRC_HI.
REQ-018 IDLE: tx_valid=0, in_ready=0; start=1 -> latch pid and zlp, crc=16'hFFFF, count=0, next state PID.
REQ-019 PID: tx_valid=1, tx_data={~pid,pid}; on handshake -> CRC_LO if zlp latched, else DATA.
REQ-020 DATA: tx_data=in_data, tx_valid=in_valid and in_ready=tx_ready, combinationally, with no added latency.
REQ-021 DATA: a payload transfer is in_valid&tx_ready; each transfer updates crc and increments count.
REQ-022 DATA: transfer with in_last=1 -> CRC_LO.
REQ-023 DATA overrun: a transfer without in_last that makes count==MAX_BYTES -> len_err pulse (next cycle), then CRC_LO.
REQ-024 DATA overrun: source bytes after the overrun SHALL NOT be accepted (in_ready=0 outside DATA).
REQ-025 CRC algorithm: CRC-16/USB; reflected polynomial 16'hA001, init 16'hFFFF, bytes LSB-first.
REQ-026 CRC per-byte update: 8 iterations of crc = (crc>>1) ^ ((crc[0]^bit) ? 16'hA001 : 0).
REQ-027 CRC_LO: tx_valid=1, tx_data=~crc[7:0]; on handshake -> CRC_HI.
REQ-028 CRC_HI: tx_valid=1, tx_data=~crc[15:8]; on handshake -> IDLE.
REQ-029 done=1 for exactly one cycle, the cycle after the CRC_HI handshake (state is IDLE).
REQ-030 start in the cycle done is high SHALL be accepted normally.
REQ-031 In PID/CRC_LO/CRC_HI, tx_valid SHALL stay high and tx_data stable until tx_ready.
REQ-032 start while busy SHALL be ignored; pid/zlp changes while busy SHALL have no effect.
REQ-033 in_last outside DATA SHALL be ignored; in_data/in_valid are never consumed outside DATA.

Reset
REQ-034 reset=0 at a clock edge -> IDLE, crc=16'hFFFF, count=0.
REQ-035 Reset output values: tx_valid=0, in_ready=0, busy=0, done=0, len_err=0.
REQ-036 Reset mid-packet SHALL abort the packet: no done, no CRC bytes emitted.
REQ-037 After reset release, the block SHALL accept start on the first cycle.

Verification
REQ-038 ZLP: start, pid=4'hB, zlp=1, tx_ready=1 -> tx bytes 0x4B, 0x00, 0x00; done pulse one cycle later; busy low.
REQ-039 Check vector: pid=4'h3, payload 0x31..0x39 (in_last on 0x39), tx_ready=1 -> wire bytes 0xC3, 0x31..0x39, 0xC8, 0xB4.
REQ-040 Back-pressure: tx_ready=0 for 3 cycles in PID and in CRC_LO -> tx_data held (0xC3 / CRC low byte), no state advance, no byte loss.
REQ-041 Source gaps: in_valid deasserted 2 cycles between payload bytes -> tx_valid low during gap, count/crc unchanged, final CRC identical to the gap-free run.
REQ-042 Overrun: MAX_BYTES=4, source sends 5 bytes with no in_last -> exactly 4 payload bytes sent, len_err pulse, 5th byte not accepted, valid CRC over the 4 bytes.
REQ-043 Reset in DATA after 2 bytes, then new ZLP packet -> tx_valid=0 the cycle after reset, no done; new packet yields 0xC3, 0x00, 0x00 for pid=4'h3.
